// File: rtl/sweep_scheduler.sv
// -----------------------------------------------------------------------------
// sweep_scheduler
//   Sequences a triangle datapath. It issues enable strobes at a programmable
//   rate, tracks which half of the triangle the strobe belongs to, and counts
//   completed periods. One period is 2*(2^N-1) strobes.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          asynchronous active-low reset
//   start        level; begins a sweep when seen high in IDLE
//   stop         level; aborts any activity (highest priority)
//   pause        level; freezes a running sweep while high
//   divisor      strobe spacing, one strobe every divisor+1 cycles
//   cycles       number of periods to run, 0 = run until stop
//   ena          registered one-cycle strobe for the datapath enable
//   phase        registered, 0 = rising half, 1 = falling half
//   busy         high while running or paused
//   done         registered one-cycle pulse at sweep completion
//   cycles_done  completed periods of the current or last sweep
// -----------------------------------------------------------------------------
module sweep_scheduler #(
    parameter int N     = 8,
    parameter int DIV_W = 16,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [DIV_W-1:0] divisor,
    input  logic [CYC_W-1:0] cycles,
    output logic             ena,
    output logic             phase,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycles_done
);

    localparam int STEP_W = N + 1;
    localparam int STEPS  = 2 * ((1 << N) - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_HALF = STEP_W'((1 << N) - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state;
    logic [DIV_W-1:0]  presc;
    logic [DIV_W-1:0]  div_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [STEP_W-1:0] step;
    logic [CYC_W-1:0]  cd_inc;

    assign busy   = (state == S_RUN) || (state == S_PAUSED);
    assign cd_inc = cycles_done + CYC_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            ena         <= 1'b0;
            phase       <= 1'b0;
            done        <= 1'b0;
            cycles_done <= '0;
            presc       <= '0;
            step        <= '0;
            div_q       <= '0;
            cyc_q       <= '0;
        end else begin
            // Both strobes default low; only the paths below raise them.
            ena  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state       <= S_RUN;
                        div_q       <= divisor;
                        cyc_q       <= cycles;
                        presc       <= '0;
                        step        <= '0;
                        cycles_done <= '0;
                        phase       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        presc <= '0;
                        step  <= '0;
                        phase <= 1'b0;
                    end else if (pause) begin
                        state <= S_PAUSED;
                    end else if (presc == div_q) begin
                        presc <= '0;
                        ena   <= 1'b1;
                        // Phase describes the strobe being issued, so it is
                        // taken from the step value before it advances.
                        phase <= (step >= STEP_HALF);
                        if (step == STEP_LAST) begin
                            step        <= '0;
                            cycles_done <= cd_inc;
                            // The last strobe of the final period still goes out.
                            if (cyc_q != '0 && cd_inc == cyc_q)
                                state <= S_DONE;
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end else begin
                        presc <= presc + DIV_W'(1);
                    end
                end
                S_PAUSED: begin
                    if (stop) begin
                        state <= S_IDLE;
                        presc <= '0;
                        step  <= '0;
                        phase <= 1'b0;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end
                default: begin  // S_DONE
                    // done is raised here, one cycle after the final strobe,
                    // so it never overlaps ena.
                    state <= S_IDLE;
                    if (stop) begin
                        presc <= '0;
                        step  <= '0;
                        phase <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
module tb_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] divisor = '0;
    logic [7:0]  cycles = '0;
    logic        ena, phase, busy, done;
    logic [7:0]  cycles_done;

    sweep_scheduler #(.N(3), .DIV_W(16), .CYC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .divisor(divisor), .cycles(cycles), .ena(ena), .phase(phase),
        .busy(busy), .done(done), .cycles_done(cycles_done)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; read only on falling edges.
    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int   e;
        logic ph;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Every strobe must match the next scoreboard entry in edge and phase.
    always @(negedge clk) begin
        if (rst && ena) begin
            exp_t x;
            if (sb.size() == 0) begin
                chk("extra_ena", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                chk("ena_edge", ecnt, x.e);
                chk("ena_phase", {31'd0, phase}, {31'd0, x.ph});
            end
            chk("ena_done_excl", {31'd0, done}, 32'd0);
        end
    end

    // Expected strobes of one sweep started at edge e0. A 10-cycle pause whose
    // first sampled edge is e0+poff costs 11 counting edges (entry, 9 held, exit).
    task automatic push_sweep(input int e0, input int d, input int n, input int poff);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.e = e0 + (k + 1) * (d + 1);
            if (poff >= 0 && x.e >= e0 + poff) x.e += 11;
            x.ph = ((k % 14) >= 7);
            sb.push_back(x);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic launch(input int d, input int c, input int n, input int poff, output int e0);
        divisor = 16'(d);
        cycles  = 8'(c);
        start   = 1'b1;
        e0      = ecnt + 1;
        push_sweep(e0, d, n, poff);
        @(negedge clk);
        start   = 1'b0;
        // Later changes must not affect the running sweep.
        divisor = 16'($urandom_range(0, 5));
        cycles  = 8'($urandom_range(0, 5));
    endtask

    task automatic wait_done(input int exp_e, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                chk("done_edge", ecnt, exp_e);
                seen = 1'b1;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_1cyc", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    int e0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ena", {31'd0, ena}, 32'd0);
        chk("rst_phase", {31'd0, phase}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cd", {24'd0, cycles_done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // divisor=0, one period: 14 back-to-back strobes then done
        launch(0, 1, 14, -1, e0);
        wait_done(e0 + 14 + 1, 100);
        chk("t1_cd", {24'd0, cycles_done}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_sb", sb.size(), 32'd0);

        // divisor=2, two periods: 28 strobes every 3rd cycle
        launch(2, 2, 28, -1, e0);
        wait_done(e0 + 28 * 3 + 1, 200);
        chk("t2_cd", {24'd0, cycles_done}, 32'd2);
        chk("t2_sb", sb.size(), 32'd0);

        // pause for 10 cycles starting at edge e0+9
        launch(1, 1, 14, 9, e0);
        repeat (8) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        chk("t3_busy_paused", {31'd0, busy}, 32'd1);
        repeat (9) @(negedge clk);
        pause = 1'b0;
        wait_done(e0 + 14 * 2 + 11 + 1, 200);
        chk("t3_cd", {24'd0, cycles_done}, 32'd1);
        chk("t3_sb", sb.size(), 32'd0);

        // endless sweep, stop after 20 strobes
        launch(1, 0, 20, -1, e0);
        wait_drain(100);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4_ena", {31'd0, ena}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_cd", {24'd0, cycles_done}, 32'd1);
        chk("t4_phase", {31'd0, phase}, 32'd0);
        repeat (4) @(negedge clk);

        // asynchronous reset mid-sweep, between clock edges
        launch(0, 0, 100, -1, e0);
        repeat (23) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_ena", {31'd0, ena}, 32'd0);
        chk("t5_phase", {31'd0, phase}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_cd", {24'd0, cycles_done}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);

        // start held across done restarts from IDLE on the following edge
        divisor = 16'd0;
        cycles  = 8'd1;
        start   = 1'b1;
        e0      = ecnt + 1;
        push_sweep(e0, 0, 14, -1);
        push_sweep(e0 + 16, 0, 14, -1);
        wait_done(e0 + 15, 100);
        start = 1'b0;
        chk("t7_busy", {31'd0, busy}, 32'd1);
        wait_done(e0 + 16 + 15, 100);
        chk("t7_cd", {24'd0, cycles_done}, 32'd1);
        chk("t7_sb", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
